teclado_digitos: RTL and testbench

//  Producer of the digitos_value/digitos_valid interface consumed by setup and the lock FSM.

---
 rtl/teclado_digitos_pkg.sv | 59 +++++
 rtl/teclado_digitos_varredura.sv | 135 +++++++++++++
 rtl/teclado_digitos.sv | 132 +++++++++++++
 tb/tb_teclado_digitos.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_digitos_pkg.sv
// Shared types, packet constants and keypad decode helpers for the keypad digit producer.
package teclado_digitos_pkg;

  localparam int unsigned N_DIG = 20;
  localparam int unsigned DIG_W = 4;

  typedef struct packed {
    logic [N_DIG-1:0][DIG_W-1:0] digits;
  } senhaPac_t;

  localparam senhaPac_t SENHA_VAZIA   = '{digits: {N_DIG{4'hF}}};
  localparam senhaPac_t SENHA_SAIR    = '{digits: {N_DIG{4'hB}}};
  localparam senhaPac_t SENHA_TIMEOUT = '{digits: {N_DIG{4'hE}}};

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, T_AST, T_HASH, T_LETRA
  } tecla_t;

  typedef enum logic [2:0] {
    ST_SCAN, ST_DEB_PRESS, ST_ACCEPT, ST_HELD, ST_DEB_REL
  } scan_state_t;

  // Map a (row, column) position to its key code.
  function automatic tecla_t decode_tecla(input logic [1:0] row, input logic [1:0] col);
    tecla_t t;
    case ({row, col})
      4'd0:    t = T1;
      4'd1:    t = T2;
      4'd2:    t = T3;
      4'd4:    t = T4;
      4'd5:    t = T5;
      4'd6:    t = T6;
      4'd8:    t = T7;
      4'd9:    t = T8;
      4'd10:   t = T9;
      4'd12:   t = T_AST;
      4'd13:   t = T0;
      4'd14:   t = T_HASH;
      default: t = T_LETRA;
    endcase
    return t;
  endfunction

  // True when exactly one active-low column is asserted.
  function automatic logic one_low(input logic [3:0] col);
    return ($countones(~col) == 1);
  endfunction

  // Index of the lowest asserted (low) column.
  function automatic logic [1:0] col_idx(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/teclado_digitos_varredura.sv
// Keypad row scanner: column synchroniser, row rotation, press/release debounce, hold timer.
module varredura_matriz
  import teclado_digitos_pkg::*;
#(
  parameter int unsigned SCAN_CYC     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned LONG_CYC     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_matriz,
  output logic [3:0] lin_matriz,
  output tecla_t     tecla,
  output logic       press_c,
  output logic       release_c,
  output logic       long_c
);

  localparam int unsigned SCAN_W = $clog2(SCAN_CYC + 1);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
  // Columns seen through the synchroniser lag a row change by two cycles.
  localparam int unsigned SETTLE = 2;

  scan_state_t       state_q, state_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [1:0]        row_q, row_d;
  logic [3:0]        lin_q, lin_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        pat_q, pat_d;
  tecla_t            tecla_q, tecla_d;

  // State and datapath registers, including the two-flop column synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      row_q      <= 2'd0;
      lin_q      <= 4'b1110;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      pat_q      <= 4'hF;
      tecla_q    <= T_LETRA;
    end else begin
      state_q    <= state_d;
      sync1_q    <= col_matriz;
      sync2_q    <= sync1_q;
      row_q      <= row_d;
      lin_q      <= lin_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pat_q      <= pat_d;
      tecla_q    <= tecla_d;
    end
  end

  // Next-state logic: scan, debounce press, accept, hold, debounce release.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    pat_d      = pat_q;
    tecla_d    = tecla_q;
    press_c    = 1'b0;
    release_c  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_W'(SCAN_CYC - 1)) begin
          scan_cnt_d = '0;
          row_d      = row_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
        if (scan_cnt_q >= SCAN_W'(SETTLE) && one_low(sync2_q)) begin
          pat_d      = sync2_q;
          tecla_d    = decode_tecla(row_q, col_idx(sync2_q));
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          row_d      = row_q;
          state_d    = ST_DEB_PRESS;
        end
      end
      ST_DEB_PRESS: begin
        if (sync2_q != pat_q) begin
          scan_cnt_d = '0;
          state_d    = ST_SCAN;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
          state_d = ST_ACCEPT;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      ST_ACCEPT: begin
        press_c    = 1'b1;
        hold_cnt_d = '0;
        state_d    = ST_HELD;
      end
      ST_HELD: begin
        if (sync2_q == 4'hF) begin
          deb_cnt_d = '0;
          state_d   = ST_DEB_REL;
        end else if (hold_cnt_q < HOLD_W'(LONG_CYC)) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_DEB_REL: begin
        if (sync2_q != 4'hF) begin
          state_d = ST_HELD;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
          release_c  = 1'b1;
          hold_cnt_d = '0;
          scan_cnt_d = '0;
          row_d      = row_q + 2'd1;
          state_d    = ST_SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = ST_SCAN;
    endcase
    lin_d = ~(4'(1) << row_d);
  end

  assign lin_matriz = lin_q;
  assign tecla      = tecla_q;
  assign long_c     = (hold_cnt_q >= HOLD_W'(LONG_CYC));

endmodule

// File: rtl/teclado_digitos.sv
// Keypad digit producer: digit buffer, key actions, inactivity timeout and packet output.
module teclado_digitos
  import teclado_digitos_pkg::*;
#(
  parameter int unsigned SCAN_CYC     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned LONG_CYC     = 100_000_000,
  parameter int unsigned TIMEOUT_CYC  = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_matriz,
  output logic [3:0] lin_matriz,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid,
  output logic       tecla_evt
);

  localparam int unsigned CNT_W = $clog2(N_DIG + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  tecla_t tecla;
  logic   press_c, release_c, long_c;

  varredura_matriz #(
    .SCAN_CYC    (SCAN_CYC),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC)
  ) u_varredura (
    .clk       (clk),
    .rst       (rst),
    .col_matriz(col_matriz),
    .lin_matriz(lin_matriz),
    .tecla     (tecla),
    .press_c   (press_c),
    .release_c (release_c),
    .long_c    (long_c)
  );

  senhaPac_t         buffer_q, buffer_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              exit_sent_q, exit_sent_d;
  senhaPac_t         value_q, value_d;
  logic              valid_q, valid_d;
  logic              evt_q, evt_d;
  logic              emit_c, exit_now_c;
  senhaPac_t         pkt_c;

  // Buffer, timer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q    <= SENHA_VAZIA;
      count_q     <= '0;
      timer_q     <= '0;
      exit_sent_q <= 1'b0;
      value_q     <= SENHA_VAZIA;
      valid_q     <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      buffer_q    <= buffer_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      exit_sent_q <= exit_sent_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      evt_q       <= evt_d;
    end
  end

  // Key actions; an accept outranks exit, exit outranks timeout, one emit per cycle.
  always_comb begin
    buffer_d    = buffer_q;
    count_d     = count_q;
    timer_d     = timer_q;
    exit_sent_d = exit_sent_q;
    evt_d       = 1'b0;
    emit_c      = 1'b0;
    pkt_c       = SENHA_VAZIA;
    exit_now_c  = long_c && (tecla == T_AST) && !exit_sent_q;
    if (press_c) begin
      exit_sent_d = 1'b0;
      timer_d     = '0;
      case (tecla)
        T_HASH: begin
          evt_d    = 1'b1;
          emit_c   = 1'b1;
          pkt_c    = buffer_q;
          buffer_d = SENHA_VAZIA;
          count_d  = '0;
        end
        T_AST:   evt_d = 1'b1;
        T_LETRA: evt_d = 1'b0;
        default: begin
          evt_d           = 1'b1;
          buffer_d.digits = {buffer_q.digits[N_DIG-2:0], 4'(tecla)};
          if (count_q != CNT_W'(N_DIG)) count_d = count_q + CNT_W'(1);
        end
      endcase
    end else if (exit_now_c) begin
      emit_c      = 1'b1;
      pkt_c       = SENHA_SAIR;
      buffer_d    = SENHA_VAZIA;
      count_d     = '0;
      exit_sent_d = 1'b1;
    end else begin
      // Short '*' press acts on release as a backspace.
      if (release_c && (tecla == T_AST) && !exit_sent_q && (count_q != '0)) begin
        buffer_d.digits = {4'hF, buffer_q.digits[N_DIG-1:1]};
        count_d         = count_q - CNT_W'(1);
      end
      if (count_q == '0) begin
        timer_d = '0;
      end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
        emit_c   = 1'b1;
        pkt_c    = SENHA_TIMEOUT;
        buffer_d = SENHA_VAZIA;
        count_d  = '0;
        timer_d  = '0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
    valid_d = emit_c;
    value_d = emit_c ? pkt_c : buffer_d;
  end

  assign digitos_value = value_q;
  assign digitos_valid = valid_q;
  assign tecla_evt     = evt_q;

endmodule

// File: tb/tb_teclado_digitos.sv
// Directed bench for teclado_digitos with a behavioural 4x4 keypad model.
module tb_teclado_digitos;
  import teclado_digitos_pkg::*;

  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6;
  localparam int K7 = 8, K8 = 9, K9 = 10, KAST = 12, KHASH = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_matriz;
  logic [3:0] lin_matriz;
  senhaPac_t  digitos_value;
  logic       digitos_valid;
  logic       tecla_evt;

  teclado_digitos #(
    .SCAN_CYC(4), .DEBOUNCE_CYC(8), .LONG_CYC(64), .TIMEOUT_CYC(200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .col_matriz   (col_matriz),
    .lin_matriz   (lin_matriz),
    .digitos_value(digitos_value),
    .digitos_valid(digitos_valid),
    .tecla_evt    (tecla_evt)
  );

  always #5 clk = ~clk;

  // Keypad: the held key pulls its column low while its row is driven.
  logic       key_down = 1'b0;
  logic [1:0] kr = 2'd0, kc = 2'd0;
  always_comb begin
    col_matriz = 4'hF;
    if (key_down && !lin_matriz[kr]) col_matriz[kc] = 1'b0;
  end

  // Output monitor.
  int          cyc = 0;
  int          evt_cnt = 0, valid_cnt = 0, valid_long = 0;
  int          evt_cyc = 0, valid_cyc = 0;
  logic [79:0] last_pkt = '0, after_pkt = '0;
  logic        prev_valid = 1'b0, grab_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tecla_evt) begin
      evt_cnt = evt_cnt + 1;
      evt_cyc = cyc;
    end
    if (digitos_valid && prev_valid) valid_long = valid_long + 1;
    if (digitos_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      last_pkt  = digitos_value;
      grab_next = 1'b1;
    end else if (grab_next) begin
      after_pkt = digitos_value;
      grab_next = 1'b0;
    end
    prev_valid = digitos_valid;
  end

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Packet whose low n digits are given by 'low', remainder F.
  function automatic logic [79:0] pac(input logic [79:0] low, input int n);
    logic [79:0] m;
    m = '1;
    if (n > 0) m = m << (4 * n);
    return m | low;
  endfunction

  function automatic int dkey(input int d);
    return (d == 0) ? 13 : ((d - 1) / 3) * 4 + (d - 1) % 3;
  endfunction

  task automatic set_key(input int k);
    kr = 2'(k / 4);
    kc = 2'(k % 4);
  endtask

  task automatic press_key(input int k, input int hold);
    set_key(k);
    key_down = 1'b1;
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          key;
    int          exp_evt;
    int          exp_valid;
    logic [79:0] exp_pkt;
    logic [79:0] exp_live;
  } vec_t;

  vec_t        vecs[11];
  int          e0, v0;
  logic [79:0] model;

  initial begin
    vecs[0]  = '{K1,    1, 0, 80'h0,        pac(80'h1, 1)};
    vecs[1]  = '{K2,    1, 0, 80'h0,        pac(80'h12, 2)};
    vecs[2]  = '{K3,    1, 0, 80'h0,        pac(80'h123, 3)};
    vecs[3]  = '{K4,    1, 0, 80'h0,        pac(80'h1234, 4)};
    vecs[4]  = '{KHASH, 1, 1, pac(80'h1234, 4), pac(80'h0, 0)};
    vecs[5]  = '{K7,    1, 0, 80'h0,        pac(80'h7, 1)};
    vecs[6]  = '{K8,    1, 0, 80'h0,        pac(80'h78, 2)};
    vecs[7]  = '{KAST,  1, 0, 80'h0,        pac(80'h7, 1)};
    vecs[8]  = '{KHASH, 1, 1, pac(80'h7, 1),  pac(80'h0, 0)};
    vecs[9]  = '{KA,    0, 0, 80'h0,        pac(80'h0, 0)};
    vecs[10] = '{K9,    1, 0, 80'h0,        pac(80'h9, 1)};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_lin",   80'(lin_matriz), 80'(4'b1110));
    chk("rst_value", digitos_value, pac(80'h0, 0));
    chk("rst_valid", 80'(digitos_valid), 80'(0));
    chk("rst_evt",   80'(tecla_evt), 80'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table of clean presses.
    for (int i = 0; i < 11; i++) begin
      e0 = evt_cnt;
      v0 = valid_cnt;
      press_key(vecs[i].key, 40);
      chk($sformatf("v%0d_evt", i),   80'(evt_cnt - e0),   80'(vecs[i].exp_evt));
      chk($sformatf("v%0d_valid", i), 80'(valid_cnt - v0), 80'(vecs[i].exp_valid));
      if (vecs[i].exp_valid != 0) begin
        chk($sformatf("v%0d_pkt", i),   last_pkt,  vecs[i].exp_pkt);
        chk($sformatf("v%0d_after", i), after_pkt, vecs[i].exp_live);
      end
      chk($sformatf("v%0d_live", i), digitos_value, vecs[i].exp_live);
    end

    // Long '*' hold with buffer holding 9: one EXIT, no backspace afterwards.
    e0 = evt_cnt;
    v0 = valid_cnt;
    press_key(KAST, 140);
    chk("exit_evt",   80'(evt_cnt - e0),   80'(1));
    chk("exit_valid", 80'(valid_cnt - v0), 80'(1));
    chk("exit_pkt",   last_pkt, {20{4'hB}});
    chk("exit_live",  digitos_value, pac(80'h0, 0));

    // Inactivity timeout with one digit in the buffer.
    do_reset();
    v0 = valid_cnt;
    press_key(K6, 40);
    for (int i = 0; i < 300 && valid_cnt == v0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("tmo_valid", 80'(valid_cnt - v0), 80'(1));
    chk("tmo_pkt",   last_pkt, {20{4'hE}});
    chk("tmo_delay", 80'(valid_cyc - evt_cyc), 80'(200));
    chk("tmo_live",  digitos_value, pac(80'h0, 0));

    // Empty buffer never times out.
    do_reset();
    v0 = valid_cnt;
    repeat (1000) @(negedge clk);
    chk("idle_valid", 80'(valid_cnt - v0), 80'(0));

    // Bouncy '5' then stable.
    do_reset();
    e0 = evt_cnt;
    v0 = valid_cnt;
    set_key(K5);
    for (int i = 0; i < 10; i++) begin
      key_down = ~key_down;
      repeat (3) @(negedge clk);
    end
    press_key(K5, 40);
    chk("bounce_evt",   80'(evt_cnt - e0),   80'(1));
    chk("bounce_valid", 80'(valid_cnt - v0), 80'(0));
    chk("bounce_live",  digitos_value, pac(80'h5, 1));

    // 21 digits overflow the buffer, then '#'.
    do_reset();
    e0 = evt_cnt;
    v0 = valid_cnt;
    model = '1;
    for (int i = 0; i < 21; i++) begin
      int d;
      d = (i < 20) ? (i % 10) : 1;
      press_key(dkey(d), 40);
      model = {model[75:0], 4'(d)};
    end
    chk("full_live", digitos_value, model);
    press_key(KHASH, 40);
    chk("full_evt",   80'(evt_cnt - e0),   80'(22));
    chk("full_valid", 80'(valid_cnt - v0), 80'(1));
    chk("full_pkt",   last_pkt, model);
    chk("full_d0",    80'(last_pkt[3:0]), 80'(1));

    // Reset while a key is held, then the key is re-accepted as a new press.
    set_key(K5);
    key_down = 1'b1;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_lin",   80'(lin_matriz), 80'(4'b1110));
    chk("mid_value", digitos_value, pac(80'h0, 0));
    chk("mid_valid", 80'(digitos_valid), 80'(0));
    chk("mid_evt",   80'(tecla_evt), 80'(0));
    rst = 1'b0;
    e0 = evt_cnt;
    repeat (40) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_reaccept", 80'(evt_cnt - e0), 80'(1));
    chk("mid_live",     digitos_value, pac(80'h5, 1));

    chk("valid_width", 80'(valid_long), 80'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
